// File: rtl/data_loader_pkg.sv
// Shared constants for the UART-driven memory loader: widths, default bit
// timing and the state encodings used by the loader FSM and the receiver.
package data_loader_pkg;

  localparam int ADDR_W               = 18;
  localparam int DATA_W               = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 434;  // 50 MHz / 115200 baud

  // Loader FSM encoding
  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_LOADING = 2'b01;
  localparam logic [1:0] ST_DONE    = 2'b10;

  // UART receiver encoding
  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_WAIT  = 3'd4;

endpackage

// File: rtl/data_loader_uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit sampling,
// false-start rejection and stop-bit error reporting.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = data_loader_pkg::CLKS_PER_BIT_DEFAULT,
  parameter int DATA_W       = data_loader_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_serial,
  output logic              rx_tick,
  output logic [DATA_W-1:0] rx_byte,
  output logic              rx_err
);
  import data_loader_pkg::*;

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  logic              rx_s1, rx_s2, rx_prev;
  logic [2:0]        rx_state;
  logic [CNT_W-1:0]  clk_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shift;

  // Bring the asynchronous line into the clock domain; rx_prev gives edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_serial;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Frame sequencer: start check at half bit, then data and stop at bit centres
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      rx_byte  <= '0;
      rx_tick  <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_tick <= 1'b0;
      rx_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          clk_cnt <= '0;
          if (rx_prev && !rx_s2) rx_state <= RX_START;
        end
        RX_START: begin
          if (clk_cnt == HALF_END) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            // Line back high at mid start bit: treat as noise and drop it
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (clk_cnt == BIT_END) begin
            clk_cnt <= '0;
            shift   <= {rx_s2, shift[DATA_W-1:1]};
            if (bit_idx == LAST_IDX) rx_state <= RX_STOP;
            else                     bit_idx  <= bit_idx + 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (clk_cnt == BIT_END) begin
            clk_cnt <= '0;
            if (rx_s2) begin
              rx_tick  <= 1'b1;
              rx_byte  <= shift;
              rx_state <= RX_IDLE;
            end else begin
              // Broken frame: wait for the line to recover before hunting again
              rx_err   <= 1'b1;
              rx_state <= RX_WAIT;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_WAIT: begin
          if (rx_s2) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/data_loader.sv
// Loads a block of memory from a UART byte stream: each received byte is
// written at the next address from 0 up to the end address latched when
// the start button is pressed.
module data_loader #(
  parameter int CLKS_PER_BIT = data_loader_pkg::CLKS_PER_BIT_DEFAULT,
  parameter int ADDR_W       = data_loader_pkg::ADDR_W,
  parameter int DATA_W       = data_loader_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_serial,
  input  logic              start,
  input  logic [ADDR_W-1:0] end_add,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] din,
  output logic              wen,
  output logic              busy,
  output logic              fin,
  output logic              frame_err
);
  import data_loader_pkg::*;

  logic              rx_tick, rx_err;
  logic [DATA_W-1:0] rx_byte;
  logic              st_s1, st_s2, st_prev;
  logic              arm;
  logic [1:0]        state;
  logic [ADDR_W-1:0] end_lat;

  uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_W       (DATA_W)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_serial (rx_serial),
    .rx_tick   (rx_tick),
    .rx_byte   (rx_byte),
    .rx_err    (rx_err)
  );

  // Synchronise the active-low button and keep the previous value for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_s1   <= 1'b1;
      st_s2   <= 1'b1;
      st_prev <= 1'b1;
    end else begin
      st_s1   <= start;
      st_s2   <= st_s1;
      st_prev <= st_s2;
    end
  end

  assign arm = st_prev & ~st_s2;

  // Loader FSM: arm in IDLE, write one byte per rx_tick, stop after end address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      addr      <= '0;
      din       <= '0;
      wen       <= 1'b0;
      busy      <= 1'b0;
      fin       <= 1'b0;
      frame_err <= 1'b0;
      end_lat   <= '0;
    end else begin
      wen <= 1'b0;
      case (state)
        ST_IDLE: begin
          addr <= '0;
          if (arm) begin
            end_lat   <= end_add;
            fin       <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_LOADING;
          end
        end
        ST_LOADING: begin
          if (rx_tick) begin
            wen <= 1'b1;
            din <= rx_byte;
          end
          if (rx_err) frame_err <= 1'b1;
          // Advance only after a write lands; the final address is never exceeded
          if (wen) begin
            if (addr == end_lat) state <= ST_DONE;
            else                 addr  <= addr + 1'b1;
          end
        end
        ST_DONE: begin
          fin   <= 1'b1;
          busy  <= 1'b0;
          addr  <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/data_loader.md
DATA_LOADER -- requirements
Module: data_loader

Interface
REQ-001 Parameter: CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200).
REQ-002 Parameter: ADDR_W, 18, memory address width.
REQ-003 Parameter: DATA_W, 8, UART byte / memory word width.
REQ-004 Port: clk  input  1  single system clock; all logic on rising edge.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: rx_serial  input  1  asynchronous UART line, idle high, 8N1, LSB first.
REQ-007 Port: start  input  1  active-low push button; load armed on its falling edge.
REQ-008 Port: end_add  input  ADDR_W  last address to write; sampled at arming.
REQ-009 Port: addr  output  ADDR_W  memory write address.
REQ-010 Port: din  output  DATA_W  memory write data.
REQ-011 Port: wen  output  1  one-cycle memory write enable.
REQ-012 Port: busy  output  1  high while in LOADING or DONE.
REQ-013 Port: fin  output  1  high from load completion until next arming.
REQ-014 Port: frame_err  output  1  sticky; set by any stop-bit error during LOADING.

Function
REQ-015 rx_serial SHALL pass a 2-flop synchroniser before any use.
REQ-016 Receiver: falling edge on synchronised line starts a frame; line re-sampled at CLKS_PER_BIT/2; high there = false start, frame abandoned, no output.
REQ-017 Receiver: data bits sampled at bit centres, LSB first; stop bit sampled at its centre.
REQ-018 Receiver: valid stop (1) -> one-cycle rx_tick with rx_byte; stop = 0 -> rx_err pulse, no rx_tick, byte discarded, receiver waits for line high before next start.
REQ-019 start synchronised by 2 flops (reset value 1); arm event = synchronised old 1, new 0.
REQ-020 FSM states IDLE, LOADING, DONE; reset state IDLE.
REQ-021 IDLE: addr held 0, wen 0; rx_tick ignored; on arm: latch end_add, clear fin and frame_err, busy <= 1, go LOADING.
REQ-022 LOADING: rx_tick at cycle N -> cycle N+1 has wen = 1, din = rx_byte, addr = current write address.
REQ-023 LOADING: addr increments by 1 on the cycle after each wen pulse, unless that write was to latched end_add.
REQ-024 LOADING: write to latched end_add -> go DONE next cycle; addr stays at end_add.
REQ-025 DONE: one cycle; fin <= 1, busy <= 0, go IDLE (addr returns to 0 there).
REQ-026 latched end_add = 0 -> exactly one byte written at address 0, then DONE.
REQ-027 end_add = 2^ADDR_W-1 -> full space written; addr never wraps past end_add.
REQ-028 Arm events during LOADING or DONE ignored; end_add changes after arming ignored.
REQ-029 rx_err during LOADING sets frame_err; address not advanced; loading continues.
REQ-030 wen never asserted in two consecutive cycles (byte spacing >= 10*CLKS_PER_BIT).

Reset
REQ-031 rst_n low SHALL immediately force: state IDLE, addr 0, din 0, wen 0, busy 0, fin 0, frame_err 0, receiver idle, synchroniser flops 1.
REQ-032 Reset mid-load SHALL abandon the load with no further writes; memory contents untouched.
REQ-033 After rst_n release, a new load requires a fresh arm event.

Structure
REQ-034 Shared package SHALL hold: state encoding (IDLE 2'b00, LOADING 2'b01, DONE 2'b10), ADDR_W, DATA_W, default CLKS_PER_BIT.
REQ-035 Sub-module uart_rx_core SHALL contain REQ-015..018 (outputs rx_tick, rx_byte, rx_err); FSM and addressing stay in data_loader.

Verification (CLKS_PER_BIT = 16)
REQ-036 end_add=3, arm, send 0xA5,0x3C,0xFF,0x01 -> wen pulses at addr 0..3 with those bytes, fin=1, busy=0, addr=0.
REQ-037 end_add=0, arm, send 0x55,0x66 -> single write 0x55 @0, fin=1; 0x66 produces no wen.
REQ-038 end_add=2, arm, send 0x11, frame with stop=0, 0x22, 0x33 -> writes 0x11@0, 0x22@1, 0x33@2; frame_err=1.
REQ-039 Send 0x77 before arming; 4-cycle low glitch on rx_serial -> no wen, fin=0, busy=0.
REQ-040 end_add=5, assert rst_n low after 2nd write -> all outputs 0 immediately; new arm with end_add=1 writes @0,@1.
REQ-041 end_add=4, second start press mid-load and end_add changed to 1 -> load still ends at addr 4.
